alu_muldiv: RTL and testbench
=============================

Name: alu_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit with HI/LO result registers. It pairs with the single-cycle ALU in the execute stage. It covers MULT, MULTU, DIV, DIVU, MTHI and MTLO. MFHI and MFLO read the registered hi/lo outputs directly. The datapath is iterative, one bit per cycle, so the pipeline stalls on busy.

Parameters:
WIDTH, 32, operand and HI/LO width in bits (>= 4)
CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only while idle (busy=0)
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved
a  in  WIDTH  rs operand (multiplicand / dividend / move source)
b  in  WIDTH  rt operand (multiplier / divisor)
flush  in  1  synchronous abort of an in-flight op
busy  out  1  operation in progress; pipeline must stall
done  out  1  one-cycle pulse: hi/lo just updated
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (rst_n=0, any time, including mid-operation): state=IDLE, busy=0, done=0, hi=0, lo=0, counter and work registers=0.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - start with MULT/MULTU/DIV/DIVU at edge E0: latch |a|,|b| (signed ops) or a,b (unsigned ops), plus the result sign bits; counter=0; go to RUN.
  - start with MTHI/MTLO at E0: hi (or lo) <= a at E0; done=1 for the cycle after E0; stay IDLE; busy stays 0.
  - start with a reserved op: ignored; no state change, no done.
- RUN: one iteration per edge. Multiply is shift-add over a 2*WIDTH accumulator. Divide is restoring shift-subtract. After WIDTH iterations (edge E0+WIDTH) go to FIX.
- FIX: apply sign correction, write hi/lo at edge E0+WIDTH+1, go to IDLE.
- Timing:
  - busy=1 exactly while state is RUN or FIX, i.e. for WIDTH+1 cycles.
  - done=1 for the single cycle after busy falls; hi/lo hold the new values in that same cycle.
- start is ignored while busy=1; no queueing.
- A start in the done cycle is accepted (back-to-back ops).
- Multiply: {hi,lo} = full 2*WIDTH product. MULT is two's-complement signed; MULTU is unsigned.
- Divide: lo = quotient, hi = remainder.
  - DIV truncates toward zero; remainder takes the sign of the dividend.
  - DIVU is unsigned.
- Divide by zero (b=0): lo = all ones, hi = a. No trap.
- Signed overflow (a = most negative value, b = -1): lo = most negative value, hi = 0.
- flush=1 while busy: return to IDLE at the next edge; hi/lo unchanged; no done pulse.
- flush has priority over start in the same cycle; flush while idle has no effect.
- Outputs are registered only; there is no combinational path from inputs to busy/done/hi/lo.

Decomposition:
- Shared package alu_pkg holds:
  - op encoding constants (OP_MULT..OP_MTLO);
  - the FSM state typedef (IDLE/RUN/FIX);
  - the divide-by-zero fill constant.
  The existing ALU operation codes also move there.
- One natural sub-module: muldiv_step.
  - Combinational single-iteration datapath: one shift-add or shift-subtract step on {acc, q}, selected by a mul/div bit.
  - Instantiated once; the FSM, counter and sign handling stay in alu_muldiv.

Test Plan (WIDTH=32):
1. MULT a=FFFFFFFD (-3), b=00000007 -> after 33 busy cycles, done pulse; hi=FFFFFFFF, lo=FFFFFFEB.
2. MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001. A second start issued while busy is ignored (hi/lo change once, exactly one done).
3. DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD (-3), hi=FFFFFFFF (-1). Then DIVU a=00000064, b=0 -> lo=FFFFFFFF, hi=00000064.
4. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=00000000. Then a back-to-back MTLO a=12345678 in the done cycle -> lo=12345678 one cycle later, busy never asserted.
5. Start DIVU 100/7, assert flush at cycle 10 -> busy drops next edge, no done, hi/lo keep prior values. Restart DIVU 100/7 -> lo=0000000E, hi=00000002.
6. Start MULT 5*5, drop rst_n at cycle 12 (asynchronous, mid-cycle) -> busy, done, hi, lo all 0 immediately. After release, MTHI a=A5A5A5A5 -> hi=A5A5A5A5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared execute-stage definitions: ALU op codes, mul/div op encoding and FSM states.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_FIX  = 2'd2;

    // Divide-by-zero quotient is this bit replicated across the full width.
    localparam logic DIV0_FILL_BIT = 1'b1;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface alu_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, flush, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, flush, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem;
    logic [WIDTH:0] diff;

    // NOTE: every output is assigned on every path, so no latch is inferred.
    always_comb begin
        sum  = {1'b0, acc_i} + (q_i[0] ? {1'b0, d_i} : '0);
        rem  = {acc_i, q_i[WIDTH-1]};
        diff = rem - {1'b0, d_i};
        if (is_div_i) begin
            // Top bit of diff set means the trial subtraction borrowed: restore.
            if (diff[WIDTH]) begin
                acc_o = rem[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = diff[WIDTH-1:0];
                q_o   = {q_i[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_o = sum[WIDTH:1];
            q_o   = {sum[0], q_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit with HI/LO registers; one bit per cycle, stalls via busy.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic         clk,
    input logic         rst_n,
    alu_muldiv_if.slave mdu
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             is_div_q, is_div_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             div0_q, div0_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             signed_op, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH-1:0] step_acc, step_q;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign signed_op = ~mdu.op[0];
    assign sa        = signed_op & mdu.a[WIDTH-1];
    assign sb        = signed_op & mdu.b[WIDTH-1];
    assign mag_a     = sa ? -mdu.a : mdu.a;
    assign mag_b     = sb ? -mdu.b : mdu.b;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .q_i      (quo_q),
        .d_i      (dvs_q),
        .acc_o    (step_acc),
        .q_o      (step_q)
    );

    // Magnitudes were iterated; restore signs here. Remainder follows the dividend.
    assign prod     = {acc_q, quo_q};
    assign prod_fix = neg_q_q ? -prod : prod;
    assign quo_fix  = div0_q ? {WIDTH{DIV0_FILL_BIT}} : (neg_q_q ? -quo_q : quo_q);
    assign rem_fix  = neg_r_q ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mdu.start && !mdu.flush) begin
                    if (is_iter_op(mdu.op)) begin
                        state_d  = ST_RUN;
                        cnt_d    = '0;
                        acc_d    = '0;
                        is_div_d = mdu.op[1];
                        quo_d    = mdu.op[1] ? mag_a : mag_b;
                        dvs_d    = mdu.op[1] ? mag_b : mag_a;
                        neg_q_d  = sa ^ sb;
                        neg_r_d  = sa;
                        div0_d   = (mdu.b == '0);
                    end else if (mdu.op == OP_MTHI) begin
                        hi_d   = mdu.a;
                        done_d = 1'b1;
                    end else if (mdu.op == OP_MTLO) begin
                        lo_d   = mdu.a;
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (mdu.flush) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = step_acc;
                    quo_d = step_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!mdu.flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop updates together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            div0_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            div0_q   <= div0_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign mdu.busy = (state_q != ST_IDLE);
    assign mdu.done = done_q;
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32.
module tb_alu_muldiv;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    alu_muldiv_if #(.WIDTH(32)) mdu ();

    alu_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (mdu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // Issue one request, then count busy cycles; returns positioned in the first idle cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cycles);
        @(negedge clk);
        mdu.start = 1'b1;
        mdu.op    = op;
        mdu.a     = a;
        mdu.b     = b;
        @(negedge clk);
        mdu.start = 1'b0;
        busy_cycles = 0;
        while (mdu.busy && busy_cycles < 100) begin
            busy_cycles++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        mdu.start = 1'b0;
        mdu.op    = 3'b000;
        mdu.a     = '0;
        mdu.b     = '0;
        mdu.flush = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({mdu.busy, mdu.done, mdu.hi, mdu.lo} !== 66'd0)
            $display("FAIL reset_outputs got busy=%b done=%b hi=%h lo=%h expected all zero",
                     mdu.busy, mdu.done, mdu.hi, mdu.lo);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reserved;
        @(negedge clk);
        mdu.start = 1'b1;
        mdu.op    = 3'b110;
        mdu.a     = 32'h1111_2222;
        @(negedge clk);
        mdu.start = 1'b0;
        total_cnt++;
        if ({mdu.busy, mdu.done, mdu.hi, mdu.lo} !== 66'd0)
            $display("FAIL reserved_ignored got busy=%b done=%b hi=%h lo=%h expected all zero",
                     mdu.busy, mdu.done, mdu.hi, mdu.lo);
        else pass_cnt++;
    endtask

    task automatic test_mult;
        int n;
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, n);
        total_cnt++;
        if (n !== 33) $display("FAIL mult_busy_cycles got %0d expected 33", n);
        else pass_cnt++;
        total_cnt++;
        if (mdu.done !== 1'b1) $display("FAIL mult_done got %b expected 1", mdu.done);
        else pass_cnt++;
        total_cnt++;
        if (mdu.hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi got %h expected FFFFFFFF", mdu.hi);
        else pass_cnt++;
        total_cnt++;
        if (mdu.lo !== 32'hFFFF_FFEB) $display("FAIL mult_lo got %h expected FFFFFFEB", mdu.lo);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (mdu.done !== 1'b0) $display("FAIL mult_done_single got %b expected 0", mdu.done);
        else pass_cnt++;
    endtask

    task automatic test_multu_busy_start;
        int n;
        int dones;
        @(negedge clk);
        mdu.start = 1'b1;
        mdu.op    = OP_MULTU;
        mdu.a     = 32'hFFFF_FFFF;
        mdu.b     = 32'hFFFF_FFFF;
        @(negedge clk);
        mdu.start = 1'b0;
        n = 0;
        dones = 0;
        for (int i = 0; i < 50; i++) begin
            if (i == 5) begin
                mdu.start = 1'b1;
                mdu.op    = OP_MTHI;
                mdu.a     = 32'hDEAD_BEEF;
            end else begin
                mdu.start = 1'b0;
            end
            if (mdu.busy) n++;
            if (mdu.done) dones++;
            @(negedge clk);
        end
        total_cnt++;
        if (n !== 33) $display("FAIL multu_busy_cycles got %0d expected 33", n);
        else pass_cnt++;
        total_cnt++;
        if (dones !== 1) $display("FAIL multu_done_count got %0d expected 1", dones);
        else pass_cnt++;
        total_cnt++;
        if (mdu.hi !== 32'hFFFF_FFFE) $display("FAIL multu_hi got %h expected FFFFFFFE", mdu.hi);
        else pass_cnt++;
        total_cnt++;
        if (mdu.lo !== 32'h0000_0001) $display("FAIL multu_lo got %h expected 00000001", mdu.lo);
        else pass_cnt++;
    endtask

    task automatic test_div;
        int n;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, n);
        total_cnt++;
        if (n !== 33 || mdu.done !== 1'b1)
            $display("FAIL div_timing got cycles=%0d done=%b expected 33/1", n, mdu.done);
        else pass_cnt++;
        total_cnt++;
        if (mdu.lo !== 32'hFFFF_FFFD) $display("FAIL div_lo got %h expected FFFFFFFD", mdu.lo);
        else pass_cnt++;
        total_cnt++;
        if (mdu.hi !== 32'hFFFF_FFFF) $display("FAIL div_hi got %h expected FFFFFFFF", mdu.hi);
        else pass_cnt++;
        run_op(OP_DIVU, 32'h0000_0064, 32'h0000_0000, n);
        total_cnt++;
        if (mdu.lo !== 32'hFFFF_FFFF) $display("FAIL divu0_lo got %h expected FFFFFFFF", mdu.lo);
        else pass_cnt++;
        total_cnt++;
        if (mdu.hi !== 32'h0000_0064) $display("FAIL divu0_hi got %h expected 00000064", mdu.hi);
        else pass_cnt++;
    endtask

    task automatic test_overflow_back_to_back;
        int n;
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
        total_cnt++;
        if (mdu.lo !== 32'h8000_0000) $display("FAIL ovf_lo got %h expected 80000000", mdu.lo);
        else pass_cnt++;
        total_cnt++;
        if (mdu.hi !== 32'h0000_0000) $display("FAIL ovf_hi got %h expected 00000000", mdu.hi);
        else pass_cnt++;
        mdu.start = 1'b1;
        mdu.op    = OP_MTLO;
        mdu.a     = 32'h1234_5678;
        @(negedge clk);
        mdu.start = 1'b0;
        total_cnt++;
        if (mdu.lo !== 32'h1234_5678 || mdu.done !== 1'b1)
            $display("FAIL b2b_mtlo got lo=%h done=%b expected 12345678/1", mdu.lo, mdu.done);
        else pass_cnt++;
        total_cnt++;
        if (mdu.busy !== 1'b0) $display("FAIL b2b_busy got %b expected 0", mdu.busy);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (mdu.busy !== 1'b0 || mdu.done !== 1'b0)
            $display("FAIL b2b_after got busy=%b done=%b expected 0/0", mdu.busy, mdu.done);
        else pass_cnt++;
    endtask

    task automatic test_flush;
        int n;
        @(negedge clk);
        mdu.start = 1'b1;
        mdu.op    = OP_DIVU;
        mdu.a     = 32'd100;
        mdu.b     = 32'd7;
        @(negedge clk);
        mdu.start = 1'b0;
        repeat (9) @(negedge clk);
        total_cnt++;
        if (mdu.busy !== 1'b1) $display("FAIL flush_prebusy got %b expected 1", mdu.busy);
        else pass_cnt++;
        mdu.flush = 1'b1;
        @(negedge clk);
        mdu.flush = 1'b0;
        total_cnt++;
        if (mdu.busy !== 1'b0 || mdu.done !== 1'b0)
            $display("FAIL flush_abort got busy=%b done=%b expected 0/0", mdu.busy, mdu.done);
        else pass_cnt++;
        total_cnt++;
        if (mdu.hi !== 32'h0 || mdu.lo !== 32'h1234_5678)
            $display("FAIL flush_hold got hi=%h lo=%h expected 00000000/12345678", mdu.hi, mdu.lo);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (mdu.done !== 1'b0) $display("FAIL flush_no_done got %b expected 0", mdu.done);
        else pass_cnt++;
        run_op(OP_DIVU, 32'd100, 32'd7, n);
        total_cnt++;
        if (n !== 33 || mdu.done !== 1'b1)
            $display("FAIL restart_timing got cycles=%0d done=%b expected 33/1", n, mdu.done);
        else pass_cnt++;
        total_cnt++;
        if (mdu.lo !== 32'h0000_000E || mdu.hi !== 32'h0000_0002)
            $display("FAIL restart_result got hi=%h lo=%h expected 00000002/0000000E", mdu.hi, mdu.lo);
        else pass_cnt++;
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        mdu.start = 1'b1;
        mdu.op    = OP_MULT;
        mdu.a     = 32'd5;
        mdu.b     = 32'd5;
        @(negedge clk);
        mdu.start = 1'b0;
        repeat (11) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({mdu.busy, mdu.done, mdu.hi, mdu.lo} !== 66'd0)
            $display("FAIL async_reset got busy=%b done=%b hi=%h lo=%h expected all zero",
                     mdu.busy, mdu.done, mdu.hi, mdu.lo);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mdu.start = 1'b1;
        mdu.op    = OP_MTHI;
        mdu.a     = 32'hA5A5_A5A5;
        @(negedge clk);
        mdu.start = 1'b0;
        total_cnt++;
        if (mdu.hi !== 32'hA5A5_A5A5 || mdu.done !== 1'b1 || mdu.busy !== 1'b0)
            $display("FAIL mthi_after_reset got hi=%h done=%b busy=%b expected A5A5A5A5/1/0",
                     mdu.hi, mdu.done, mdu.busy);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        test_reset();
        test_reserved();
        test_mult();
        test_multu_busy_start();
        test_div();
        test_overflow_back_to_back();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
